// File: rtl/systolic_ctrl_nxn.sv
// ---------------------------------------------------------------------------
// systolic_ctrl_nxn
//   Feeder/sequencer for an external NxN output-stationary systolic array.
//   On a start handshake it captures A, B and the job mode. It then drives
//   row/column operand streams, skewed one cycle per lane, into the array,
//   along with array clear/enable. It raises done once the array result is
//   valid.
//
// Ports
//   i_clk      clock, rising edge
//   i_rst_n    synchronous active-low reset
//   i_start    job request, accepted only in IDLE or DONE
//   i_mode     0 = overwrite (clear accumulators), 1 = accumulate
//   i_abort    cancel the current job (ignored in IDLE)
//   i_A, i_B   NxN operand matrices, element [r][c] at bits (r*N+c)*W +: W
//   o_a_feed   row lanes, lane r at bits r*W +: W
//   o_b_feed   column lanes, lane c at bits c*W +: W
//   o_arr_en   array enable
//   o_clr      one-cycle accumulator clear
//   o_busy     job in progress
//   o_done     result valid, held in DONE
// ---------------------------------------------------------------------------
module systolic_ctrl_nxn #(
  parameter int W         = 32,
  parameter int N         = 3,
  parameter int ARRAY_LAT = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_mode,
  input  logic             i_abort,
  input  logic [W*N*N-1:0] i_A,
  input  logic [W*N*N-1:0] i_B,
  output logic [W*N-1:0]   o_a_feed,
  output logic [W*N-1:0]   o_b_feed,
  output logic             o_arr_en,
  output logic             o_clr,
  output logic             o_busy,
  output logic             o_done
);

  // state | meaning
  // IDLE  | no job, waiting for start
  // CLEAR | one cycle, accumulator clear unless accumulating
  // FEED  | N cycles, step k injects column k of A / row k of B
  // DRAIN | 2N-2+ARRAY_LAT cycles, skew lines flush and array settles
  // DONE  | result valid, waits for start or abort
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_FEED  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int DRAIN_LEN = 2 * N - 2 + ARRAY_LAT;
  localparam int CW        = $clog2(2 * N + ARRAY_LAT + 1);
  // Lane j owns j+1 stages (input stage plus j delay stages, last one drives
  // the output), packed triangularly so that no stage is unused.
  localparam int NSTG      = (N * (N + 1)) / 2;

  localparam logic [CW-1:0] FEED_LOAD  = CW'(N - 1);
  localparam logic [CW-1:0] DRAIN_LOAD = CW'((DRAIN_LEN > 0) ? DRAIN_LEN - 1 : 0);

  function automatic int lane_base(input int r);
    return (r * (r + 1)) / 2;
  endfunction

  logic [2:0]    state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          take_job;
  logic          abort_hit;
  logic          busy_d;
  int            k_d;

  logic [W-1:0]  a_q  [N][N];
  logic [W-1:0]  b_q  [N][N];
  logic [W-1:0]  a_in [N];
  logic [W-1:0]  b_in [N];
  logic [W-1:0]  a_sk [NSTG];
  logic [W-1:0]  b_sk [NSTG];

  assign abort_hit = i_abort && (state != S_IDLE);

  // Next-state and down-counter. The counter is reloaded on every state
  // entry and only decremented toward its terminal count of zero.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    take_job = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_start) begin
          state_d  = S_CLEAR;
          cnt_d    = '0;
          take_job = 1'b1;
        end
      end
      S_CLEAR: begin
        if (i_abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          state_d = S_FEED;
          cnt_d   = FEED_LOAD;
        end
      end
      S_FEED: begin
        if (i_abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt == '0) begin
          if (DRAIN_LEN > 0) begin
            state_d = S_DRAIN;
            cnt_d   = DRAIN_LOAD;
          end else begin
            state_d = S_DONE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      S_DRAIN: begin
        if (i_abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt == '0) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      S_DONE: begin
        // abort wins over a simultaneous start
        if (i_abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (i_start) begin
          state_d  = S_CLEAR;
          cnt_d    = '0;
          take_job = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy_d = (state_d == S_CLEAR) || (state_d == S_FEED) || (state_d == S_DRAIN);

  // Values entering the skew lines on the coming edge. In FEED the step
  // index is counted up from the down-counter: k = N-1-cnt.
  always_comb begin
    k_d = (N - 1) - int'(cnt_d);
    for (int r = 0; r < N; r++) begin
      a_in[r] = '0;
      b_in[r] = '0;
      if (state_d == S_FEED) begin
        for (int kk = 0; kk < N; kk++) begin
          if (kk == k_d) begin
            a_in[r] = a_q[r][kk];
            b_in[r] = b_q[kk][r];
          end
        end
      end
    end
  end

  // Operand capture at the accepting edge; inputs are don't-care afterwards.
  always_ff @(posedge i_clk) begin
    if (take_job) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          a_q[r][c] <= i_A[(r * N + c) * W +: W];
          b_q[r][c] <= i_B[(r * N + c) * W +: W];
        end
      end
    end
  end

  // Control state and registered flags. The clear pulse is decided at the
  // accepting edge, so it uses the incoming mode directly.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      o_busy   <= 1'b0;
      o_arr_en <= 1'b0;
      o_clr    <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      o_busy   <= busy_d;
      o_arr_en <= busy_d;
      o_clr    <= take_job && !i_mode;
      o_done   <= (state_d == S_DONE);
    end
  end

  // Skew delay lines. Zeros are injected outside FEED, so DRAIN flushes them.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || abort_hit) begin
      for (int s = 0; s < NSTG; s++) begin
        a_sk[s] <= '0;
        b_sk[s] <= '0;
      end
    end else begin
      for (int r = 0; r < N; r++) begin
        a_sk[lane_base(r)] <= a_in[r];
        b_sk[lane_base(r)] <= b_in[r];
        for (int i = 1; i <= r; i++) begin
          a_sk[lane_base(r) + i] <= a_sk[lane_base(r) + i - 1];
          b_sk[lane_base(r) + i] <= b_sk[lane_base(r) + i - 1];
        end
      end
    end
  end

  always_comb begin
    o_a_feed = '0;
    o_b_feed = '0;
    for (int r = 0; r < N; r++) begin
      o_a_feed[r * W +: W] = a_sk[lane_base(r) + r];
      o_b_feed[r * W +: W] = b_sk[lane_base(r) + r];
    end
  end

endmodule

// File: tb/tb_systolic_ctrl_nxn.sv
module tb_systolic_ctrl_nxn;
  localparam int W    = 32;
  localparam int N    = 3;
  localparam int LAT  = 1;
  localparam int DREL = 3 * N + LAT;
  localparam int HN   = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, start, mode, abort;
  logic [W*N*N-1:0] A, B;
  logic [W*N-1:0]   a_feed, b_feed;
  logic             arr_en, clr, busy, done;

  systolic_ctrl_nxn #(.W(W), .N(N), .ARRAY_LAT(LAT)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_mode(mode), .i_abort(abort),
    .i_A(A), .i_B(B), .o_a_feed(a_feed), .o_b_feed(b_feed),
    .o_arr_en(arr_en), .o_clr(clr), .o_busy(busy), .o_done(done)
  );

  logic       s1_start;
  logic [7:0] s1_A, s1_a, s1_b;
  logic       s1_en, s1_clr, s1_busy, s1_done;
  systolic_ctrl_nxn #(.W(8), .N(1), .ARRAY_LAT(0)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(s1_start), .i_mode(1'b0), .i_abort(1'b0),
    .i_A(s1_A), .i_B(s1_A), .o_a_feed(s1_a), .o_b_feed(s1_b),
    .o_arr_en(s1_en), .o_clr(s1_clr), .o_busy(s1_busy), .o_done(s1_done)
  );

  logic         s4_start;
  logic [127:0] s4_A;
  logic [31:0]  s4_a, s4_b;
  logic         s4_en, s4_clr, s4_busy, s4_done;
  systolic_ctrl_nxn #(.W(8), .N(4), .ARRAY_LAT(2)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(s4_start), .i_mode(1'b0), .i_abort(1'b0),
    .i_A(s4_A), .i_B(s4_A), .o_a_feed(s4_a), .o_b_feed(s4_b),
    .o_arr_en(s4_en), .o_clr(s4_clr), .o_busy(s4_busy), .o_done(s4_done)
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, ec, got, exp);
    end
  endtask

  // Reference model: a job is described only by its start cycle and the
  // captured operands; everything else follows from the cycle offset.
  int          ec = 0;
  int          js = 0;
  int          p_rel, n_rel;
  bit          m_act = 0;
  bit          m_mode = 0;
  logic [W-1:0] ma [N][N];
  logic [W-1:0] mb [N][N];

  always @(posedge clk) begin
    p_rel = ec - js + 1;
    if (!rst_n) m_act = 0;
    else if (m_act && abort) m_act = 0;
    else if (start && (!m_act || p_rel >= DREL)) begin
      m_act  = 1;
      js     = ec + 1;
      m_mode = mode;
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          ma[r][c] = A[(r*N+c)*W +: W];
          mb[r][c] = B[(r*N+c)*W +: W];
        end
    end
    ec = ec + 1;
  end

  logic [W*N-1:0] ea, eb;
  logic [W*N-1:0] h_a [HN];
  logic [W*N-1:0] h_b [HN];
  logic           h_clr [HN], h_en [HN], h_busy [HN], h_done [HN];
  logic [7:0]     h1_a [HN], h1_b [HN];
  logic           h1_done [HN], h1_busy [HN], h1_clr [HN], h1_en [HN];
  logic [31:0]    h4_a [HN], h4_b [HN];
  logic           h4_done [HN], h4_en [HN], h4_clr [HN], h4_busy [HN];

  always @(negedge clk) begin
    if (chk_en) begin
      n_rel = ec - js + 1;
      ea = '0;
      eb = '0;
      if (m_act)
        for (int r = 0; r < N; r++)
          for (int k = 0; k < N; k++)
            if (n_rel - 2 - r == k) begin
              ea[r*W +: W] = ma[r][k];
              eb[r*W +: W] = mb[k][r];
            end
      chk("a_feed", a_feed, ea);
      chk("b_feed", b_feed, eb);
      chk("busy",   busy,   m_act && n_rel <= DREL - 1);
      chk("arr_en", arr_en, m_act && n_rel <= DREL - 1);
      chk("clr",    clr,    m_act && n_rel == 1 && !m_mode);
      chk("done",   done,   m_act && n_rel >= DREL);
    end
    if (ec < HN) begin
      h_a[ec] = a_feed; h_b[ec] = b_feed; h_clr[ec] = clr; h_en[ec] = arr_en;
      h_busy[ec] = busy; h_done[ec] = done;
      h1_a[ec] = s1_a; h1_b[ec] = s1_b; h1_done[ec] = s1_done; h1_busy[ec] = s1_busy;
      h1_clr[ec] = s1_clr; h1_en[ec] = s1_en;
      h4_a[ec] = s4_a; h4_b[ec] = s4_b; h4_done[ec] = s4_done; h4_en[ec] = s4_en;
      h4_clr[ec] = s4_clr; h4_busy[ec] = s4_busy;
    end
  end

  int t0;

  task automatic start_job(input logic m);
    start = 1'b1;
    mode  = m;
    @(negedge clk);
    t0    = ec;
    start = 1'b0;
  endtask

  task automatic goto(input int x);
    while (ec - t0 + 1 < x) @(negedge clk);
  endtask

  function automatic int hx(input int tb, input int x);
    return tb + x - 1;
  endfunction

  task automatic rand_ab();
    for (int i = 0; i < N*N; i++) begin
      A[i*W +: W] = $urandom;
      B[i*W +: W] = $urandom;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", ec);
    $fatal(1);
  end

  int   ta, tbj, tc, td, ts;
  logic acc;

  initial begin
    rst_n = 0; start = 0; mode = 0; abort = 0; A = '0; B = '0;
    s1_start = 0; s1_A = '0; s4_start = 0; s4_A = '0;
    repeat (3) @(negedge clk);
    chk_en = 1;
    chk("rst_a_feed", a_feed, 0);
    chk("rst_b_feed", b_feed, 0);
    chk("rst_flags", {busy, arr_en, clr, done}, 0);
    rst_n = 1;
    @(negedge clk);

    // job 1: known matrices, busy-time start pulse ignored
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        A[(r*N+c)*W +: W] = r*N + c + 1;
        B[(r*N+c)*W +: W] = 10 + r*N + c;
      end
    start_job(1'b0);
    ta = t0;
    rand_ab();
    goto(4); start = 1; @(negedge clk); start = 0;
    goto(12);
    chk("j1_clr_t1", h_clr[hx(ta,1)], 1);
    chk("j1_clr_t2", h_clr[hx(ta,2)], 0);
    for (int k = 0; k < 3; k++) begin
      chk("j1_a0",  h_a[hx(ta,2+k)][31:0],  1 + k);
      chk("j1_a2",  h_a[hx(ta,4+k)][95:64], 7 + k);
      chk("j1_b1",  h_b[hx(ta,3+k)][63:32], 11 + 3*k);
      chk("j1_b2",  h_b[hx(ta,4+k)][95:64], 12 + 3*k);
    end
    chk("j1_a2_t3", h_a[hx(ta,3)][95:64], 0);
    chk("j1_a2_t7", h_a[hx(ta,7)][95:64], 0);
    chk("j1_done_t9",  h_done[hx(ta,9)], 0);
    chk("j1_done_t10", h_done[hx(ta,10)], 1);
    chk("j1_done_t11", h_done[hx(ta,11)], 1);

    // job 2: accumulate mode, started from DONE
    rand_ab();
    start_job(1'b1);
    tbj = t0;
    goto(12);
    chk("j2_done_t1", h_done[hx(tbj,1)], 0);
    acc = 0;
    for (int x = 1; x <= 10; x++) acc = acc | h_clr[hx(tbj,x)];
    chk("j2_clr_never", acc, 0);
    acc = 1;
    for (int x = 1; x <= 9; x++) acc = acc & h_en[hx(tbj,x)];
    chk("j2_en_t1_9", acc, 1);
    chk("j2_en_t10", h_en[hx(tbj,10)], 0);
    chk("j2_done_t10", h_done[hx(tbj,10)], 1);

    // job 3: abort during FEED
    rand_ab();
    start_job(1'b0);
    tc = t0;
    goto(3); abort = 1; @(negedge clk); abort = 0;
    goto(13);
    chk("j3_busy_t3", h_busy[hx(tc,3)], 1);
    acc = 0;
    for (int x = 4; x <= 12; x++)
      acc = acc | h_busy[hx(tc,x)] | h_en[hx(tc,x)] | h_done[hx(tc,x)] | h_clr[hx(tc,x)]
                | (|h_a[hx(tc,x)]) | (|h_b[hx(tc,x)]);
    chk("j3_abort_quiet", acc, 0);

    // job 4: reset mid-job
    rand_ab();
    start_job(1'b0);
    td = t0;
    goto(5); rst_n = 0; @(negedge clk); rst_n = 1;
    goto(13);
    chk("j4_busy_t5", h_busy[hx(td,5)], 1);
    acc = 0;
    for (int x = 6; x <= 12; x++)
      acc = acc | h_busy[hx(td,x)] | h_en[hx(td,x)] | h_done[hx(td,x)] | h_clr[hx(td,x)]
                | (|h_a[hx(td,x)]) | (|h_b[hx(td,x)]);
    chk("j4_reset_quiet", acc, 0);

    // N=1/LAT=0 and N=4/LAT=2 instances
    s1_A = 8'h5A;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) s4_A[(r*4+c)*8 +: 8] = 8'(16*r + c + 1);
    s1_start = 1; s4_start = 1;
    @(negedge clk);
    t0 = ec; ts = ec;
    s1_start = 0; s4_start = 0;
    s1_A = $urandom; s4_A = {$urandom, $urandom, $urandom, $urandom};
    goto(17);
    chk("n1_clr_t1",  h1_clr[hx(ts,1)], 1);
    chk("n1_a_t1",    h1_a[hx(ts,1)], 0);
    chk("n1_a_t2",    h1_a[hx(ts,2)], 8'h5A);
    chk("n1_b_t2",    h1_b[hx(ts,2)], 8'h5A);
    chk("n1_a_t3",    h1_a[hx(ts,3)], 0);
    chk("n1_busy_t2", {h1_busy[hx(ts,2)], h1_en[hx(ts,2)]}, 2'b11);
    chk("n1_done_t2", h1_done[hx(ts,2)], 0);
    chk("n1_done_t3", {h1_done[hx(ts,3)], h1_busy[hx(ts,3)]}, 2'b10);
    chk("n4_clr_t1",  h4_clr[hx(ts,1)], 1);
    chk("n4_a3_t4",   h4_a[hx(ts,4)][31:24], 0);
    chk("n4_a3_t5",   h4_a[hx(ts,5)][31:24], 49);
    chk("n4_b3_t5",   h4_b[hx(ts,5)][31:24], 4);
    chk("n4_a3_t8",   h4_a[hx(ts,8)][31:24], 52);
    chk("n4_a3_t9",   h4_a[hx(ts,9)][31:24], 0);
    chk("n4_en_t13",  {h4_en[hx(ts,13)], h4_busy[hx(ts,13)]}, 2'b11);
    chk("n4_done_t13", h4_done[hx(ts,13)], 0);
    chk("n4_done_t14", {h4_done[hx(ts,14)], h4_en[hx(ts,14)]}, 2'b10);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 9) < 3);
      mode  = 1'($urandom);
      abort = ($urandom_range(0, 49) == 0);
      rst_n = ($urandom_range(0, 299) != 0);
      rand_ab();
      @(negedge clk);
    end
    start = 0; abort = 0; rst_n = 1;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
